// File: rtl/pipe_stage.sv
// Purpose : DEPTH-stage valid/ready register pipeline with bubble collapse and synchronous flush.
// Latency : DEPTH cycles from the in_valid/in_ready handshake to out_valid; one entry per cycle sustained.
// Backpres: combinational ready chain, so a stage accepts whenever it is empty or the stage below moves.
//
// Ports   : CLK, nRST (async active-low) | in_valid/in_ready/in_data (upstream)
//           flush (kills all in-flight entries) | out_valid/out_ready/out_data (downstream)
//           occupancy (valid-stage count, only when PIPE_OCCUPANCY_EN is defined)
module pipe_stage #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data
`ifdef PIPE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q  [DEPTH];
  logic [WIDTH-1:0] d_d  [DEPTH];
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] up_v;
  logic [WIDTH-1:0] up_d [DEPTH];

  // r[k] = stage k may load this cycle: it is empty, or everything below it
  // can move. Built with a running accumulator so the chain has no
  // self-referencing vector.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc  = ~v_q[k] | acc;
      r[k] = acc;
    end
  end

  // Upstream view of each stage: the input port for stage 0, the previous
  // stage otherwise.
  always_comb begin : upstream
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v_q[k-1];
      up_d[k] = d_q[k-1];
    end
  end

  always_comb begin : next_state
    v_d = v_q;
    d_d = d_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        v_d[k] = 1'b0;
        if (CLEAR_DATA != 0) begin
          d_d[k] = '0;
        end
      end else if (r[k]) begin
        v_d[k] = up_v[k];
        // Payload only moves with a valid entry so an idle stage keeps its
        // last data instead of picking up garbage.
        if (up_v[k]) begin
          d_d[k] = up_d[k];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  // Flush blocks both handshakes in the same cycle it is asserted.
  assign in_ready  = r[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  // Registered popcount of the next-state valid bits, so it always matches
  // v_q after the same edge.
  always_comb begin : occ_count
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_stage.sv
`timescale 1ns/1ps
module tb_pipe_stage;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n;
  int   n_pass;
  int   n_total;

  // DEPTH=3, WIDTH=32
  logic        a3_iv, a3_ir, a3_fl, a3_ov, a3_ordy;
  logic [31:0] a3_id, a3_od;
  // DEPTH=4, WIDTH=32
  logic        a4_iv, a4_ir, a4_fl, a4_ov, a4_ordy;
  logic [31:0] a4_id, a4_od;
  // DEPTH=2, WIDTH=32, CLEAR_DATA=1
  logic        a2_iv, a2_ir, a2_fl, a2_ov, a2_ordy;
  logic [31:0] a2_id, a2_od;
  // DEPTH=1, WIDTH=8
  logic        a1_iv, a1_ir, a1_fl, a1_ov, a1_ordy;
  logic [7:0]  a1_id, a1_od;
`ifdef PIPE_OCCUPANCY_EN
  logic [1:0]  a3_occ;
  logic [2:0]  a4_occ;
  logic [1:0]  a2_occ;
  logic [0:0]  a1_occ;
`endif

  pipe_stage #(.WIDTH(32), .DEPTH(3), .CLEAR_DATA(1)) u3 (
    .CLK(CLK), .nRST(rst_n), .in_valid(a3_iv), .in_ready(a3_ir), .in_data(a3_id),
    .flush(a3_fl), .out_valid(a3_ov), .out_ready(a3_ordy), .out_data(a3_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(a3_occ)
`endif
  );

  pipe_stage #(.WIDTH(32), .DEPTH(4), .CLEAR_DATA(1)) u4 (
    .CLK(CLK), .nRST(rst_n), .in_valid(a4_iv), .in_ready(a4_ir), .in_data(a4_id),
    .flush(a4_fl), .out_valid(a4_ov), .out_ready(a4_ordy), .out_data(a4_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(a4_occ)
`endif
  );

  pipe_stage #(.WIDTH(32), .DEPTH(2), .CLEAR_DATA(1)) u2 (
    .CLK(CLK), .nRST(rst_n), .in_valid(a2_iv), .in_ready(a2_ir), .in_data(a2_id),
    .flush(a2_fl), .out_valid(a2_ov), .out_ready(a2_ordy), .out_data(a2_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(a2_occ)
`endif
  );

  pipe_stage #(.WIDTH(8), .DEPTH(1), .CLEAR_DATA(1)) u1 (
    .CLK(CLK), .nRST(rst_n), .in_valid(a1_iv), .in_ready(a1_ir), .in_data(a1_id),
    .flush(a1_fl), .out_valid(a1_ov), .out_ready(a1_ordy), .out_data(a1_od)
`ifdef PIPE_OCCUPANCY_EN
    , .occupancy(a1_occ)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_occ;
  } vec_t;

  vec_t tbl [19];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic row(input int i, input logic iv, input logic [31:0] id, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_od, input int e_occ);
    tbl[i].iv = iv; tbl[i].id = id; tbl[i].ordy = ordy;
    tbl[i].e_ir = e_ir; tbl[i].e_ov = e_ov; tbl[i].e_od = e_od; tbl[i].e_occ = e_occ;
  endtask

  logic [7:0] sb [$];
  logic       m_ov, m_ir;

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    a3_iv = 0; a3_id = '0; a3_fl = 0; a3_ordy = 0;
    a4_iv = 0; a4_id = '0; a4_fl = 0; a4_ordy = 0;
    a2_iv = 0; a2_id = '0; a2_fl = 0; a2_ordy = 0;
    a1_iv = 0; a1_id = '0; a1_fl = 0; a1_ordy = 0;

    // Streaming rows: first push in row 0, head visible in row 3.
    //        i  iv    data          ordy  ir    ov    od            occ
    row( 0, 1'b1, 32'hA0000001, 1'b1, 1'b1, 1'b0, 32'h0,        0);
    row( 1, 1'b1, 32'hA0000002, 1'b1, 1'b1, 1'b0, 32'h0,        1);
    row( 2, 1'b1, 32'hA0000003, 1'b1, 1'b1, 1'b0, 32'h0,        2);
    row( 3, 1'b1, 32'hA0000004, 1'b1, 1'b1, 1'b1, 32'hA0000001, 3);
    row( 4, 1'b1, 32'hA0000005, 1'b1, 1'b1, 1'b1, 32'hA0000002, 3);
    row( 5, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA0000003, 3);
    row( 6, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA0000004, 2);
    row( 7, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA0000005, 1);
    row( 8, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hA0000005, 0);
    // Fill with downstream stalled so stage2=0x33, stage1=0x22, stage0=0x11.
    row( 9, 1'b1, 32'h33,       1'b0, 1'b1, 1'b0, 32'hA0000005, 0);
    row(10, 1'b1, 32'h22,       1'b0, 1'b1, 1'b0, 32'hA0000005, 1);
    row(11, 1'b1, 32'h11,       1'b0, 1'b1, 1'b0, 32'hA0000005, 2);
    row(12, 1'b1, 32'h44,       1'b0, 1'b0, 1'b1, 32'h33,       3);
    row(13, 1'b1, 32'h44,       1'b0, 1'b0, 1'b1, 32'h33,       3);
    // Full with both sides ready: emit 0x33 and accept 0x44 together.
    row(14, 1'b1, 32'h44,       1'b1, 1'b1, 1'b1, 32'h33,       3);
    row(15, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h22,       3);
    row(16, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h11,       2);
    row(17, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h44,       1);
    row(18, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h44,       0);

    // Reset state
    #1;
    chk1 ("reset out_valid", a3_ov, 1'b0);
    chk32("reset out_data",  a3_od, 32'h0);
    chk1 ("reset in_ready",  a3_ir, 1'b1);
`ifdef PIPE_OCCUPANCY_EN
    chk_int("reset occupancy", int'(a3_occ), 0);
`endif
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    rst_n = 1'b1;

    // Table-driven DEPTH=3 streaming and full/stall
    for (int i = 0; i < 19; i++) begin
      a3_iv = tbl[i].iv; a3_id = tbl[i].id; a3_ordy = tbl[i].ordy;
      #1;
      chk1 ($sformatf("tbl[%0d] in_ready", i),  a3_ir, tbl[i].e_ir);
      chk1 ($sformatf("tbl[%0d] out_valid", i), a3_ov, tbl[i].e_ov);
      chk32($sformatf("tbl[%0d] out_data", i),  a3_od, tbl[i].e_od);
`ifdef PIPE_OCCUPANCY_EN
      chk_int($sformatf("tbl[%0d] occupancy", i), int'(a3_occ), tbl[i].e_occ);
`endif
      cyc();
    end
    a3_iv = 0; a3_ordy = 0;

    // DEPTH=4 bubble collapse: 0x77 parked in stage 3, 0x55 must reach stage 2.
    a4_ordy = 0; a4_iv = 1; a4_id = 32'h77;
    cyc();
    a4_iv = 0;
    repeat (3) cyc();
    #1;
    chk1 ("d4 head valid", a4_ov, 1'b1);
    chk32("d4 head data",  a4_od, 32'h77);
    chk1 ("d4 ready while stalled", a4_ir, 1'b1);
    a4_iv = 1; a4_id = 32'h55;
    cyc();
    a4_iv = 0;
    repeat (4) cyc();
    #1;
    chk32("d4 head held", a4_od, 32'h77);
    chk1 ("d4 still ready", a4_ir, 1'b1);
`ifdef PIPE_OCCUPANCY_EN
    chk_int("d4 occupancy", int'(a4_occ), 2);
`endif
    a4_ordy = 1;
    #1;
    chk32("d4 emit head", a4_od, 32'h77);
    cyc();
    a4_ordy = 0;
    #1;
    // Visible immediately only if 0x55 was waiting in stage 2.
    chk1 ("d4 bubble valid", a4_ov, 1'b1);
    chk32("d4 bubble data",  a4_od, 32'h55);

    // DEPTH=2 flush with simultaneous push
    a2_ordy = 0; a2_iv = 1; a2_id = 32'h81;
    cyc();
    a2_id = 32'h82;
    cyc();
    a2_iv = 0;
    #1;
    chk1 ("d2 full valid", a2_ov, 1'b1);
    chk32("d2 full data",  a2_od, 32'h81);
    chk1 ("d2 full ready", a2_ir, 1'b0);
    a2_fl = 1; a2_iv = 1; a2_id = 32'h99; a2_ordy = 1;
    #1;
    chk1 ("d2 flush out_valid", a2_ov, 1'b0);
    chk1 ("d2 flush in_ready",  a2_ir, 1'b0);
    cyc();
    a2_fl = 0; a2_iv = 0;
    #1;
    chk1 ("d2 post-flush valid", a2_ov, 1'b0);
    chk32("d2 post-flush data",  a2_od, 32'h0);
`ifdef PIPE_OCCUPANCY_EN
    chk_int("d2 post-flush occupancy", int'(a2_occ), 0);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk1($sformatf("d2 no ghost %0d", i), a2_ov, 1'b0);
    end
    @(negedge CLK);
    a2_iv = 1; a2_id = 32'h5A;
    cyc();
    a2_iv = 0;
    #1; chk1("d2 lat cyc1", a2_ov, 1'b0);
    cyc();
    #1;
    chk1 ("d2 lat cyc2 valid", a2_ov, 1'b1);
    chk32("d2 lat cyc2 data",  a2_od, 32'h5A);
    @(negedge CLK);

    // DEPTH=1 random traffic against a scoreboard
    for (int c = 0; c < 10000; c++) begin
      a1_iv   = 1'($urandom_range(0, 1));
      a1_ordy = 1'($urandom_range(0, 1));
      a1_id   = 8'($urandom);
      #1;
      m_ov = (sb.size() != 0);
      m_ir = (sb.size() == 0) || a1_ordy;
      chk1("d1 out_valid", a1_ov, m_ov);
      chk1("d1 in_ready",  a1_ir, m_ir);
      if (m_ov) chk32("d1 out_data", {24'h0, a1_od}, {24'h0, sb[0]});
`ifdef PIPE_OCCUPANCY_EN
      chk_int("d1 occupancy", int'(a1_occ), sb.size());
`endif
      if (m_ov && a1_ordy) void'(sb.pop_front());
      if (a1_iv && m_ir)   sb.push_back(a1_id);
      cyc();
    end
    a1_iv = 0; a1_ordy = 0;

    // Asynchronous reset between edges while DEPTH=3 holds entries
    a3_ordy = 0; a3_iv = 1; a3_id = 32'hBEEF0001;
    cyc();
    a3_id = 32'hBEEF0002;
    cyc();
    a3_iv = 0;
    repeat (2) cyc();
    #1;
    chk1 ("pre-reset valid", a3_ov, 1'b1);
    chk32("pre-reset data",  a3_od, 32'hBEEF0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk1 ("async reset valid", a3_ov, 1'b0);
    chk32("async reset data",  a3_od, 32'h0);
    chk1 ("async reset ready", a3_ir, 1'b1);
`ifdef PIPE_OCCUPANCY_EN
    chk_int("async reset occupancy", int'(a3_occ), 0);
`endif
    @(negedge CLK);
    rst_n = 1'b1;
    a3_iv = 1; a3_id = 32'hC0DE0001; a3_ordy = 1;
    cyc();
    a3_iv = 0;
    for (int i = 1; i < 3; i++) begin
      #1; chk1($sformatf("post-reset lat %0d", i), a3_ov, 1'b0);
      cyc();
    end
    #1;
    chk1 ("post-reset lat 3 valid", a3_ov, 1'b1);
    chk32("post-reset lat 3 data",  a3_od, 32'hC0DE0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter DEPTH, default 1, number of register stages (1..8).
REQ-003 Parameter CLEAR_DATA, default 1, 1 = flush zeroes stage payloads, 0 = flush clears valid bits only.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream payload present.
REQ-007 in_ready  output  1  stage 0 accepts this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 flush  input  1  synchronous kill of all in-flight entries.
REQ-010 out_valid  output  1  last stage holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  WIDTH  last-stage payload.
REQ-013 occupancy  output  clog2(DEPTH+1)  count of valid stages (present only under PIPE_OCCUPANCY_EN).

Function
REQ-014 Stages SHALL be indexed 0 (input side) to DEPTH-1 (output side); each stage SHALL hold a valid bit v[k] and payload d[k].
REQ-015 out_valid SHALL equal v[DEPTH-1] AND NOT flush; out_data SHALL equal d[DEPTH-1].
REQ-016 The ready chain SHALL be combinational: r[DEPTH] = out_ready; r[k] = NOT v[k] OR r[k+1]; in_ready = r[0] AND NOT flush.
REQ-017 When r[k] is 1 and flush is 0, v[k] SHALL load the upstream valid bit (in_valid for k=0, v[k-1] otherwise); d[k] SHALL load the upstream payload only if that upstream valid bit is 1, otherwise d[k] SHALL hold.
REQ-018 When r[k] is 0, v[k] and d[k] SHALL hold.
REQ-019 Bubbles SHALL collapse: an empty stage SHALL accept from upstream even while downstream is stalled.
REQ-020 Latency through an empty pipeline SHALL be exactly DEPTH cycles from the in_valid/in_ready handshake to out_valid; sustained throughput SHALL be one entry per cycle while out_ready is held at 1.
REQ-021 No entry SHALL be dropped, duplicated or reordered outside flush; an entry with out_valid=1 and out_ready=0 SHALL hold out_data stable.
REQ-022 flush=1 SHALL clear every v[k] at the next edge, and SHALL clear every d[k] to zero if CLEAR_DATA=1; the in_data presented in that cycle SHALL be discarded.
REQ-023 flush SHALL take priority over any simultaneous in/out handshake; no transfer SHALL occur on either port in a flush cycle.
REQ-024 Full condition: all v[k]=1 and out_ready=0 SHALL force in_ready=0; simultaneous out_ready=1 and in_valid=1 when full SHALL accept and emit in the same cycle.

Reset
REQ-025 nRST=0 SHALL asynchronously clear all v[k] and all d[k] to zero, independent of CLK and CLEAR_DATA.
REQ-026 During reset, out_valid SHALL be 0, out_data SHALL be 0, in_ready SHALL be 1 (when flush=0), and occupancy SHALL be 0.
REQ-027 Reset deassertion mid-operation SHALL leave the block empty; the first accepted entry after reset SHALL follow the timing in REQ-020.

Configuration
REQ-028 Macro PIPE_OCCUPANCY_EN defined: the occupancy port SHALL exist as a register updated each edge to the population count of the next-state valid bits (0 after flush or reset).
REQ-029 Macro PIPE_OCCUPANCY_EN undefined: the occupancy port and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 DEPTH=3, WIDTH=32: push 0xA0000001..0xA0000005 on consecutive cycles with out_ready=1 -> out_valid rises 3 cycles after first push; outputs appear in order, one per cycle.
REQ-031 DEPTH=3: fill with 0x11, 0x22, 0x33 with out_ready=0 -> in_ready=0, occupancy=3, out_data=0x33 held stable; then out_ready=1 and in_valid=1 with 0x44 -> in_ready=1 and 0x33 is emitted while 0x44 is accepted in the same cycle.
REQ-032 DEPTH=4: only stage 3 is valid and out_ready=0; push 0x55 -> accepted, advances to stage 2 and stops behind the stalled entry (bubble collapse).
REQ-033 DEPTH=2, CLEAR_DATA=1: two valid entries, assert flush with in_valid=1 and data 0x99 -> next cycle out_valid=0, out_data=0, occupancy=0, 0x99 never emitted.
REQ-034 Assert nRST=0 between clock edges while the pipeline holds entries -> out_valid and out_data go to 0 immediately, without waiting for a CLK edge.
REQ-035 DEPTH=1, WIDTH=8: random in_valid/out_ready for 10000 cycles against a scoreboard queue -> no loss, duplication or reordering; occupancy is always 0 or 1.
